nios_debug_mem_access: RTL
==========================

Name: nios_debug_mem_access

Overview:
- Sysclk-domain debug memory access engine directly downstream of the CPU debug slave wrapper.
- Consumes the synchronised JTAG command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a) and the 38-bit jdo shift payload.
- Performs single-word reads and writes on an Avalon-MM master port.
- Returns MonDReg, monitor_ready and monitor_error, which feed back into the wrapper's scan chain.

Parameters:
- ADDR_W, 9, word-address width of the debug memory window.
- TIMEOUT, 255, max cycles a transfer may wait on avm_waitrequest before abort (1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- jdo  in  38  JTAG data-out payload, stable while any strobe is high.
- take_action_ocimem_a  in  1  1-cycle strobe: address load / optional read.
- take_action_ocimem_b  in  1  1-cycle strobe: write jdo[34:3] at current address.
- take_no_action_ocimem_a  in  1  1-cycle strobe: read at current address.
- avm_address  out  ADDR_W+2  byte address = {MonAReg, 2'b00}.
- avm_read  out  1  Avalon read request.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  constant 4'hF.
- avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest.
- avm_waitrequest  in  1  slave stall.
- MonDReg  out  32  last read data, or last write data.
- monitor_ready  out  1  1 = idle and last result valid.
- monitor_error  out  1  sticky error flag.

Behaviour:
- Reset values:
  - avm_read/avm_write = 0; avm_address = 0; avm_writedata = 0.
  - MonDReg = 0; MonAReg = 0.
  - monitor_ready = 1; monitor_error = 0; state = IDLE; timeout counter = 0.
- Reset mid-transfer aborts immediately; no further bus activity occurs.
- Strobe priority when simultaneous: ocimem_b > ocimem_a > no_action. Lower-priority strobes in the same cycle are discarded silently.
- Command decode (IDLE only):
  - ocimem_a: MonAReg <= jdo[ADDR_W+16:17]; monitor_error <= 0. If jdo[35]=1 go to READ, else stay IDLE.
  - no_action_ocimem_a: go to READ.
  - ocimem_b: avm_writedata <= jdo[34:3]; MonDReg <= jdo[34:3]; go to WRITE.
- Any accepted READ/WRITE command drives monitor_ready = 0 in the cycle after the strobe.
- Strobe arriving when state != IDLE: ignored and monitor_error <= 1. The in-flight transfer continues.
- READ state:
  - avm_read = 1, address held.
  - On !avm_waitrequest: MonDReg <= avm_readdata; MonAReg <= MonAReg+1; go to DONE.
- WRITE state:
  - avm_write = 1.
  - On !avm_waitrequest: MonAReg <= MonAReg+1; go to DONE.
- Timeout:
  - Counter clears on entry to READ/WRITE and increments each stalled cycle.
  - When counter == TIMEOUT and waitrequest is still high: deassert request, monitor_error <= 1, MonAReg not incremented, MonDReg unchanged, go to DONE.
- DONE: 1 cycle; monitor_ready <= 1; go to IDLE.
  - Minimum latency, strobe to monitor_ready = 1 with zero wait states: 3 cycles (strobe cycle, request cycle, DONE).
- MonAReg increment wraps modulo 2^ADDR_W; no error on wrap.
- avm_read and avm_write are never high together. Requests are held stable until accepted or aborted.
- monitor_error is cleared only by reset or ocimem_a.

Test Plan:
- Address load, no read:
  - Stimulus: ocimem_a with jdo[35]=0, jdo[25:17]=9'h010.
  - Response: no bus activity; monitor_ready stays 1; the next read drives avm_address = 11'h040.
- Load-and-read, waitrequest high 2 cycles, readdata 32'hDEADBEEF:
  - Response: avm_read high 3 cycles; MonDReg = DEADBEEF.
  - monitor_ready falls the cycle after the strobe and rises 5 cycles after the strobe.
  - Next address = 11'h044.
- Write:
  - Stimulus: ocimem_b with jdo[34:3] = 32'h12345678 at MonAReg = 9'h1FF, zero wait states.
  - Response: avm_write one cycle, avm_writedata = 12345678; MonAReg wraps to 0; monitor_error stays 0.
- Timeout, TIMEOUT=4:
  - Stimulus: waitrequest held high.
  - Response: avm_read drops after TIMEOUT cycles; monitor_error = 1; MonDReg and MonAReg unchanged.
  - A subsequent ocimem_a clears monitor_error.
- Busy overlap and simultaneous strobes:
  - Stimulus: no_action strobe during a stalled write.
  - Response: monitor_error = 1; the write still completes.
  - Stimulus: ocimem_a and ocimem_b in the same IDLE cycle.
  - Response: only the write executes.
- Reset mid-read:
  - Stimulus: assert reset while avm_read = 1.
  - Response: next cycle avm_read = 0, monitor_ready = 1, MonDReg = 0.

Source files
------------

// File: rtl/nios_debug_mem_access_if.sv
// Avalon-MM master bundle for the debug memory access engine.
// master modport: the engine (drives request, address, data, byteenable;
//                 receives readdata and waitrequest).
// slave modport:  the memory side (mirror image).
interface nios_debug_mem_access_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/nios_debug_mem_access.sv
// Debug memory access engine (system clock domain).
// Turns the synchronised JTAG OCI memory strobes into single-word Avalon-MM
// reads and writes and reports the result back to the debug scan chain.
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   jdo[37:0]                JTAG payload (address in [ADDR_W+16:17],
//                            read-after-load flag in [35], data in [34:3])
//   take_action_ocimem_a     address load, optional read
//   take_action_ocimem_b     write jdo[34:3] at the current address
//   take_no_action_ocimem_a  read at the current address
//   avm                      Avalon-MM master bundle
//   MonDReg                  last read data or last write data
//   monitor_ready            idle and last result valid
//   monitor_error            sticky error (busy collision or bus timeout)
module nios_debug_mem_access #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [37:0]                     jdo,
  input  logic                            take_action_ocimem_a,
  input  logic                            take_action_ocimem_b,
  input  logic                            take_no_action_ocimem_a,
  nios_debug_mem_access_if.master         avm,
  output logic [31:0]                     MonDReg,
  output logic                            monitor_ready,
  output logic                            monitor_error
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [15:0] TMO_MAX = 16'(TIMEOUT);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mon_a_reg;
  logic [31:0]       mon_d_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;
  logic [15:0]       tmo_reg;

  logic any_strobe;
  logic read_cmd;
  logic rd_int, wr_int, rdy_int;

  // Payload bits outside the fields this engine decodes.
  wire unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // ocimem_b wins over everything; ocimem_a wins over no_action.
  assign read_cmd = !take_action_ocimem_b &&
                    ((take_action_ocimem_a && jdo[35]) ||
                     (!take_action_ocimem_a && take_no_action_ocimem_a));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (take_action_ocimem_b) state_next = WRITE;
        else if (read_cmd)        state_next = READ;
      end
      READ, WRITE: begin
        // Abort only when the stall is still present at the limit.
        if (!avm.avm_waitrequest || tmo_reg == TMO_MAX) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    rd_int  = 1'b0;
    wr_int  = 1'b0;
    rdy_int = 1'b0;
    case (state_reg)
      IDLE:    rdy_int = 1'b1;
      READ:    rd_int  = 1'b1;
      WRITE:   wr_int  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address/data/error registers and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_a_reg <= '0;
      mon_d_reg <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
      tmo_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          tmo_reg <= '0;
          if (take_action_ocimem_b) begin
            wdata_reg <= jdo[34:3];
            mon_d_reg <= jdo[34:3];
          end else if (take_action_ocimem_a) begin
            mon_a_reg <= jdo[ADDR_W+16:17];
            err_reg   <= 1'b0;
          end
        end
        READ, WRITE: begin
          if (!avm.avm_waitrequest) begin
            if (state_reg == READ) mon_d_reg <= avm.avm_readdata;
            mon_a_reg <= mon_a_reg + ADDR_W'(1);
            tmo_reg   <= '0;
          end else if (tmo_reg == TMO_MAX) begin
            err_reg <= 1'b1;
            tmo_reg <= '0;
          end else begin
            tmo_reg <= tmo_reg + 16'd1;
          end
        end
        default: tmo_reg <= '0;
      endcase
      // A command while busy is dropped but flagged; the transfer continues.
      if (state_reg != IDLE && any_strobe) err_reg <= 1'b1;
    end
  end

  assign avm.avm_address    = {mon_a_reg, 2'b00};
  assign avm.avm_read       = rd_int;
  assign avm.avm_write      = wr_int;
  assign avm.avm_writedata  = wdata_reg;
  assign avm.avm_byteenable = 4'hF;

  assign MonDReg       = mon_d_reg;
  assign monitor_ready = rdy_int;
  assign monitor_error = err_reg;

endmodule
